batch_assembler: RTL and testbench

- Downstream stage of the scheduler's batch/acceptance stage. Consumes each accepted transaction's owner_programID and packs consecutive IDs into fixed-capacity execution batches.
- A batch is emitted when it is full or when a fill timeout expires. Emission uses a valid/ready handshake toward the executor dispatch logic.
- Applies backpressure upstream while a batch is waiting to be taken.

---
 rtl/batch_assembler.sv | 125 ++++++++++++
 tb/tb_batch_assembler.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/batch_assembler.sv
// batch_assembler
//   Packs accepted owner_programIDs into fixed-capacity execution batches.
//   A batch closes when it is full or when it has been open for
//   TIMEOUT_CYCLES edges, then it is held on a valid/ready handshake. While
//   it is held, upstream is stalled via in_ready.
//
// Optional feature: define BATCH_FLUSH_EN to add the 'flush' input, which
//   closes an open batch early. An ID accepted on the same edge is included.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     upstream ID handshake, in_programID is the ID
//   batch_valid/ready     downstream batch handshake
//   batch_ids             slot k at [k*ID_WIDTH +: ID_WIDTH], unused slots 0
//   batch_count           number of valid slots
//   batch_seq             batch sequence number, wraps at 16 bits
//   busy                  high while a batch is open or pending
//   flush                 (BATCH_FLUSH_EN only) force-close an open batch

module batch_assembler #(
  parameter int BATCH_SIZE     = 8,
  parameter int ID_WIDTH       = 64,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = $clog2(BATCH_SIZE + 1)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  input  logic [ID_WIDTH-1:0]            in_programID,
  output logic                           in_ready,
  output logic                           batch_valid,
  input  logic                           batch_ready,
  output logic [BATCH_SIZE*ID_WIDTH-1:0] batch_ids,
  output logic [CNT_W-1:0]               batch_count,
  output logic [15:0]                    batch_seq,
`ifdef BATCH_FLUSH_EN
  input  logic                           flush,
`endif
  output logic                           busy
);

  localparam int TMR_W = $clog2(TIMEOUT_CYCLES);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] FILL = 2'd1;
  localparam logic [1:0] EMIT = 2'd2;

  logic [1:0]                     state;
  logic [BATCH_SIZE*ID_WIDTH-1:0] slots;
  logic [CNT_W-1:0]               count;
  logic [TMR_W-1:0]               timer;
  logic [15:0]                    seq;

  logic flush_req;
  logic fill_full;
  logic fill_timeout;

`ifdef BATCH_FLUSH_EN
  assign flush_req = flush;
`else
  assign flush_req = 1'b0;
`endif

  // Only meaningful in FILL, where in_ready is high, so in_valid is an accept.
  assign fill_full    = in_valid && (count == CNT_W'(BATCH_SIZE - 1));
  assign fill_timeout = (timer == TMR_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      slots <= '0;
      count <= '0;
      timer <= '0;
      seq   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            // Clearing the stale upper slots here keeps unused slots zero
            // in the next emitted batch.
            slots <= {{((BATCH_SIZE - 1) * ID_WIDTH){1'b0}}, in_programID};
            count <= CNT_W'(1);
            timer <= '0;
            state <= FILL;
          end
        end
        FILL: begin
          timer <= timer + TMR_W'(1);
          if (in_valid) begin
            for (int k = 0; k < BATCH_SIZE; k++) begin
              if (count == CNT_W'(k)) begin
                slots[k*ID_WIDTH +: ID_WIDTH] <= in_programID;
              end
            end
            count <= count + CNT_W'(1);
          end
          // Any closing reason still keeps an ID accepted on this edge.
          if (fill_full || fill_timeout || flush_req) begin
            state <= EMIT;
            timer <= '0;
          end
        end
        EMIT: begin
          if (batch_ready) begin
            state <= IDLE;
            count <= '0;
            timer <= '0;
            seq   <= seq + 16'd1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign in_ready    = (state != EMIT);
  assign batch_valid = (state == EMIT);
  assign busy        = (state != IDLE);
  assign batch_ids   = slots;
  assign batch_count = count;
  assign batch_seq   = seq;

endmodule

// File: tb/tb_batch_assembler.sv
// tb_batch_assembler
//   Self-checking bench for batch_assembler with default parameters.
//   Expected batches are queued as stimulus is driven and compared when the
//   DUT completes a batch handshake.

module tb_batch_assembler;

  localparam int BS  = 8;
  localparam int IW  = 64;
  localparam int TO  = 16;
  localparam int CW  = $clog2(BS + 1);
  localparam int BW  = BS * IW;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic [IW-1:0] in_programID;
  logic          in_ready;
  logic          batch_valid;
  logic          batch_ready;
  logic [BW-1:0] batch_ids;
  logic [CW-1:0] batch_count;
  logic [15:0]   batch_seq;
  logic          busy;
`ifdef BATCH_FLUSH_EN
  logic          flush;
`endif

  typedef struct {
    int            cnt;
    logic [BW-1:0] ids;
    int            seq;
  } batch_t;

  batch_t        sb[$];
  int            vectorCount = 0;
  int            errCount    = 0;
  int            modelCnt    = 0;
  logic [BW-1:0] modelIds    = '0;
  int            expSeq      = 0;

  batch_assembler #(
    .BATCH_SIZE(BS), .ID_WIDTH(IW), .TIMEOUT_CYCLES(TO), .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_programID(in_programID),
    .in_ready(in_ready),
    .batch_valid(batch_valid),
    .batch_ready(batch_ready),
    .batch_ids(batch_ids),
    .batch_count(batch_count),
    .batch_seq(batch_seq),
`ifdef BATCH_FLUSH_EN
    .flush(flush),
`endif
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [BW-1:0] got,
                             input logic [BW-1:0] exp);
    vectorCount++;
    if (got !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of input, let the edge pass, return 1 time unit later.
  task automatic applyStimulus(input logic v, input logic [IW-1:0] id);
    in_valid     = v;
    in_programID = id;
    @(posedge clk);
    #1;
  endtask

  task automatic modelAccept(input logic [IW-1:0] id);
    modelIds[modelCnt*IW +: IW] = id;
    modelCnt++;
  endtask

  task automatic modelClear();
    modelIds = '0;
    modelCnt = 0;
  endtask

  task automatic pushExpected();
    batch_t e;
    e.cnt = modelCnt;
    e.ids = modelIds;
    e.seq = expSeq;
    sb.push_back(e);
    expSeq = (expSeq + 1) % 65536;
    modelClear();
  endtask

  // Completed handshakes are compared against the scoreboard.
  always @(negedge clk) begin
    batch_t e;
    if (rst_n && batch_valid && batch_ready) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_batch", 512'(1), 512'(0));
      end else begin
        e = sb.pop_front();
        checkOutput("sb_count", BW'(batch_count), BW'(e.cnt));
        checkOutput("sb_ids", batch_ids, e.ids);
        checkOutput("sb_seq", BW'(batch_seq), BW'(e.seq));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n        = 1'b0;
    in_valid     = 1'b0;
    in_programID = '0;
    batch_ready  = 1'b0;
`ifdef BATCH_FLUSH_EN
    flush        = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_in_ready", BW'(in_ready), BW'(1));
    checkOutput("rst_batch_valid", BW'(batch_valid), BW'(0));
    checkOutput("rst_batch_ids", batch_ids, BW'(0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rel_in_ready", BW'(in_ready), BW'(1));
    checkOutput("rel_batch_valid", BW'(batch_valid), BW'(0));
    checkOutput("rel_batch_count", BW'(batch_count), BW'(0));
    checkOutput("rel_batch_seq", BW'(batch_seq), BW'(0));
    checkOutput("rel_busy", BW'(busy), BW'(0));

    // Full batch: IDs 1..8 back to back.
    batch_ready = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      modelAccept(IW'(i));
      applyStimulus(1'b1, IW'(i));
    end
    checkOutput("full_not_early", BW'(batch_valid), BW'(0));
    modelAccept(IW'(8));
    pushExpected();
    applyStimulus(1'b1, IW'(8));
    checkOutput("full_valid", BW'(batch_valid), BW'(1));
    checkOutput("full_count", BW'(batch_count), BW'(8));
    checkOutput("full_slot0", BW'(batch_ids[0 +: IW]), BW'(1));
    checkOutput("full_slot7", BW'(batch_ids[7*IW +: IW]), BW'(8));
    checkOutput("full_seq0", BW'(batch_seq), BW'(0));
    checkOutput("full_in_ready", BW'(in_ready), BW'(0));
    applyStimulus(1'b0, '0);
    checkOutput("full_done_valid", BW'(batch_valid), BW'(0));
    checkOutput("full_seq1", BW'(batch_seq), BW'(1));
    checkOutput("full_idle_busy", BW'(busy), BW'(0));

    // Timeout: three IDs, then idle until the batch is forced out.
    modelAccept(IW'('hA));
    applyStimulus(1'b1, IW'('hA));
    for (int k = 1; k <= TO; k++) begin
      if (k == 1) begin
        modelAccept(IW'('hB));
        applyStimulus(1'b1, IW'('hB));
      end else if (k == 2) begin
        modelAccept(IW'('hC));
        pushExpected();
        applyStimulus(1'b1, IW'('hC));
      end else begin
        applyStimulus(1'b0, '0);
      end
      if (k == TO - 1) checkOutput("to_not_early", BW'(batch_valid), BW'(0));
      if (k == TO - 1) checkOutput("to_busy", BW'(busy), BW'(1));
    end
    checkOutput("to_valid", BW'(batch_valid), BW'(1));
    checkOutput("to_count", BW'(batch_count), BW'(3));
    applyStimulus(1'b0, '0);
    checkOutput("to_seq", BW'(batch_seq), BW'(2));

    // Backpressure: hold the batch while upstream keeps offering 0x55.
    for (int i = 0; i < BS; i++) begin
      modelAccept(IW'('h100 + i));
      if (i == BS - 1) pushExpected();
      applyStimulus(1'b1, IW'('h100 + i));
    end
    batch_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, IW'('h55));
      checkOutput("bp_valid", BW'(batch_valid), BW'(1));
      checkOutput("bp_in_ready", BW'(in_ready), BW'(0));
      checkOutput("bp_slot0", BW'(batch_ids[0 +: IW]), BW'('h100));
      checkOutput("bp_slot7", BW'(batch_ids[7*IW +: IW]), BW'('h107));
    end
    batch_ready = 1'b1;
    applyStimulus(1'b1, IW'('h55));
    modelAccept(IW'('h55));
    pushExpected();
    applyStimulus(1'b1, IW'('h55));
    checkOutput("bp_next_slot0", BW'(batch_ids[0 +: IW]), BW'('h55));
    checkOutput("bp_next_count", BW'(batch_count), BW'(1));
    for (int k = 0; k <= TO; k++) applyStimulus(1'b0, '0);
    checkOutput("bp_seq", BW'(batch_seq), BW'(4));

    // Mid-fill reset discards the partial batch and the sequence number.
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, IW'('h200 + i));
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #2;
    checkOutput("mr_count", BW'(batch_count), BW'(0));
    checkOutput("mr_valid", BW'(batch_valid), BW'(0));
    checkOutput("mr_seq", BW'(batch_seq), BW'(0));
    checkOutput("mr_busy", BW'(busy), BW'(0));
    @(negedge clk);
    rst_n  = 1'b1;
    expSeq = 0;
    modelClear();
    @(posedge clk);
    #1;
    applyStimulus(1'b0, '0);
    checkOutput("mr_idle_valid", BW'(batch_valid), BW'(0));
    modelAccept(IW'('h300));
    pushExpected();
    applyStimulus(1'b1, IW'('h300));
    checkOutput("mr_slot0", BW'(batch_ids[0 +: IW]), BW'('h300));
    for (int k = 0; k <= TO; k++) applyStimulus(1'b0, '0);
    checkOutput("mr_seq_after", BW'(batch_seq), BW'(1));

`ifdef BATCH_FLUSH_EN
    // Flush closes an open batch on the next edge; ignored when idle.
    flush = 1'b1;
    applyStimulus(1'b0, '0);
    checkOutput("fl_idle_busy", BW'(busy), BW'(0));
    flush = 1'b0;
    modelAccept(IW'('h1234));
    applyStimulus(1'b1, IW'('h1234));
    modelAccept(IW'('h4321));
    pushExpected();
    applyStimulus(1'b1, IW'('h4321));
    flush = 1'b1;
    applyStimulus(1'b0, '0);
    flush = 1'b0;
    checkOutput("fl_valid", BW'(batch_valid), BW'(1));
    checkOutput("fl_count", BW'(batch_count), BW'(2));
    checkOutput("fl_slot0", BW'(batch_ids[0 +: IW]), BW'('h1234));
    checkOutput("fl_slot1", BW'(batch_ids[1*IW +: IW]), BW'('h4321));
    applyStimulus(1'b0, '0);
`endif

    repeat (2) applyStimulus(1'b0, '0);
    checkOutput("sb_drained", BW'(sb.size()), BW'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, errCount);
    $finish;
  end

endmodule
